// File: rtl/lsm_sequencer_p.sv
// Load/store-multiple sequencer: walks a register list lowest index first,
// issues one word request per set bit with a MEM_REQ/MOC handshake, and
// produces the base-writeback value for the IA/IB/DA/DB addressing modes.
module lsm_sequencer_p #(
    parameter int NREGS      = 16,
    parameter int IDXW       = 4,
    parameter int AW         = 32,
    parameter int WORD_BYTES = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    input  logic [NREGS-1:0] REG_LIST,
    input  logic [AW-1:0]    BASE,
    input  logic             P_BIT,
    input  logic             U_BIT,
    input  logic             LOAD,
    input  logic             WB,
    input  logic             MOC,
    output logic             MEM_REQ,
    output logic             MEM_RW,
    output logic [AW-1:0]    MEM_ADDR,
    output logic [IDXW-1:0]  REG_IDX,
    output logic             RF_LD,
    output logic             WB_EN,
    output logic [AW-1:0]    WB_ADDR,
    output logic             BUSY,
    output logic             DONE
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS,
        S_GAP,
        S_FINISH
    } state_t;

    state_t            state_q, state_d;
    logic [NREGS-1:0]  list_q, list_d;
    logic [AW-1:0]     addr_q, addr_d;     // holds BASE during SETUP, then the walking address
    logic [AW-1:0]     fin_q, fin_d;       // final (writeback) address
    logic [IDXW:0]     cnt_q, cnt_d;       // number of registers in the list
    logic [IDXW-1:0]   idx_q, idx_d;
    logic              p_q, p_d, u_q, u_d, load_q, load_d, wb_q, wb_d;
    logic              mem_req_q, mem_req_d, rf_ld_q, rf_ld_d;
    logic              wb_en_q, wb_en_d, busy_q, busy_d, done_q, done_d;
    logic [AW-1:0]     wb_addr_q, wb_addr_d;

    logic [IDXW:0]     pop_cnt;
    logic [AW-1:0]     stride, offset;
    logic [NREGS-1:0]  list_rest;

    function automatic logic [IDXW:0] popcount(input logic [NREGS-1:0] v);
        logic [IDXW:0] c;
        c = '0;
        for (int i = 0; i < NREGS; i++) c = c + (IDXW+1)'(v[i]);
        return c;
    endfunction

    function automatic logic [IDXW-1:0] lowest_set(input logic [NREGS-1:0] v);
        logic [IDXW-1:0] r;
        r = '0;
        for (int i = NREGS - 1; i >= 0; i--) if (v[i]) r = IDXW'(i);
        return r;
    endfunction

    assign pop_cnt   = popcount(list_q);
    assign stride    = AW'(WORD_BYTES);
    assign offset    = stride * AW'(pop_cnt);
    assign list_rest = list_q & (list_q - NREGS'(1));   // list with its lowest set bit cleared

    // Next-state and registered-output logic.
    always_comb begin
        // NOTE: every target gets a default first so no path can infer a latch.
        state_d   = state_q;
        list_d    = list_q;
        addr_d    = addr_q;
        fin_d     = fin_q;
        cnt_d     = cnt_q;
        idx_d     = idx_q;
        p_d       = p_q;
        u_d       = u_q;
        load_d    = load_q;
        wb_d      = wb_q;
        rf_ld_d   = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (START) begin
                    list_d  = REG_LIST;
                    addr_d  = BASE;
                    p_d     = P_BIT;
                    u_d     = U_BIT;
                    load_d  = LOAD;
                    wb_d    = WB;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                // Lowest register always goes to the lowest address, so the
                // decrementing modes start below BASE and walk upward.
                cnt_d = pop_cnt;
                idx_d = lowest_set(list_q);
                if (u_q) begin
                    addr_d = p_q ? addr_q + stride : addr_q;
                    fin_d  = addr_q + offset;
                end else begin
                    addr_d = p_q ? addr_q - offset : addr_q - offset + stride;
                    fin_d  = addr_q - offset;
                end
                state_d = (pop_cnt == '0) ? S_FINISH : S_ACCESS;
            end
            S_ACCESS: begin
                if (MOC) begin
                    rf_ld_d = load_q;
                    list_d  = list_rest;
                    addr_d  = addr_q + stride;
                    state_d = (list_rest == '0) ? S_FINISH : S_GAP;
                end
            end
            S_GAP: begin
                // idx_q keeps the finished register through GAP so RF_LD sees it.
                idx_d   = lowest_set(list_q);
                state_d = S_ACCESS;
            end
            S_FINISH: state_d = S_IDLE;
            default:  state_d = S_IDLE;
        endcase

        mem_req_d = (state_d == S_ACCESS);
        busy_d    = (state_d != S_IDLE);
        done_d    = (state_d == S_FINISH);
        wb_en_d   = done_d && wb_q && (cnt_d != '0);
        wb_addr_d = wb_en_d ? fin_d : '0;
    end

    // State and output registers; reset aborts any operation in flight.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            state_q   <= S_IDLE;
            list_q    <= '0;
            addr_q    <= '0;
            fin_q     <= '0;
            cnt_q     <= '0;
            idx_q     <= '0;
            p_q       <= 1'b0;
            u_q       <= 1'b0;
            load_q    <= 1'b0;
            wb_q      <= 1'b0;
            mem_req_q <= 1'b0;
            rf_ld_q   <= 1'b0;
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q   <= state_d;
            list_q    <= list_d;
            addr_q    <= addr_d;
            fin_q     <= fin_d;
            cnt_q     <= cnt_d;
            idx_q     <= idx_d;
            p_q       <= p_d;
            u_q       <= u_d;
            load_q    <= load_d;
            wb_q      <= wb_d;
            mem_req_q <= mem_req_d;
            rf_ld_q   <= rf_ld_d;
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign MEM_REQ  = mem_req_q;
    assign MEM_RW   = load_q;
    assign MEM_ADDR = addr_q;
    assign REG_IDX  = idx_q;
    assign RF_LD    = rf_ld_q;
    assign WB_EN    = wb_en_q;
    assign WB_ADDR  = wb_addr_q;
    assign BUSY     = busy_q;
    assign DONE     = done_q;

endmodule

// File: doc/lsm_sequencer_p.md
Name: lsm_sequencer_p

Overview:
- Parametrised load/store-multiple sequencer.
- Replaces the fixed 16-register LSM counter.
- Walks a register list of NREGS bits and generates word addresses for all four ARM addressing modes (IA/IB/DA/DB).
- Handshakes each transfer with memory via MEM_REQ/MOC, drives the register-file index and load strobe, and produces the base-writeback value.

Parameters:
NREGS, 16, register-list width (number of architectural registers)
IDXW, 4, register index width; must equal ceil(log2(NREGS))
AW, 32, address width
WORD_BYTES, 4, address stride per transfer

Ports:
CLK  in  1  clock, rising edge
RESET  in  1  asynchronous, active-low reset
START  in  1  begin operation; sampled only in IDLE
REG_LIST  in  NREGS  register list (bit i = register i); captured on START
BASE  in  AW  base address; captured on START
P_BIT  in  1  pre-index (1 = before/B, 0 = after/A); captured on START
U_BIT  in  1  up (1 = increment/I, 0 = decrement/D); captured on START
LOAD  in  1  1 = load, 0 = store; captured on START
WB  in  1  writeback request; captured on START
MOC  in  1  memory operation complete
MEM_REQ  out  1  memory access request
MEM_RW  out  1  1 = read, 0 = write; equals captured LOAD
MEM_ADDR  out  AW  current word address
REG_IDX  out  IDXW  register being transferred (RF read port on store, RF write select on load)
RF_LD  out  1  one-cycle register-file load strobe (loads only)
WB_EN  out  1  one-cycle base-writeback strobe
WB_ADDR  out  AW  writeback value; valid while WB_EN = 1
BUSY  out  1  high in every state except IDLE
DONE  out  1  one-cycle completion pulse

Behaviour:
- Reset (RESET = 0, asynchronous): state = IDLE; all outputs 0; internal list/address/count registers cleared.
- States: IDLE, SETUP, ACCESS, GAP, FINISH.
- IDLE:
  - START = 1 captures REG_LIST, BASE, P_BIT, U_BIT, LOAD, WB, then goes to SETUP.
  - START while BUSY is ignored.
- SETUP (1 cycle):
  - N = popcount(list); N has IDXW+1 bits.
  - Start address by mode:
    - IA: BASE
    - IB: BASE + WORD_BYTES
    - DA: BASE − WORD_BYTES·N + WORD_BYTES
    - DB: BASE − WORD_BYTES·N
  - Final address: U = 1 gives BASE + WORD_BYTES·N; U = 0 gives BASE − WORD_BYTES·N.
  - All arithmetic is modulo 2^AW; wrap-around is silent.
  - N = 0: go to FINISH. Otherwise go to ACCESS.
- ACCESS:
  - MEM_REQ = 1; MEM_ADDR = current address; REG_IDX = index of lowest set bit of the remaining list.
  - Registers are always transferred in ascending index order at ascending addresses, in every mode.
  - MEM_REQ holds, with address and index stable, until MOC is sampled 1 on a rising edge.
  - On that edge:
    - RF_LD pulses for that cycle if LOAD; REG_IDX is still valid.
    - Lowest set bit is cleared.
    - Address advances by +WORD_BYTES.
    - Next state: GAP if bits remain, else FINISH.
- GAP (1 cycle): MEM_REQ = 0, then back to ACCESS. This guarantees a request low phase between transfers.
- FINISH (1 cycle):
  - DONE = 1.
  - WB_EN = 1 if WB = 1 and N ≠ 0; WB_ADDR = final address.
  - Next state: IDLE.
  - N = 0 produces no MEM_REQ and no WB_EN, only DONE.
- Latency: START→first MEM_REQ = 2 edges. Each transfer = (MOC wait + 1) cycles, plus 1 GAP cycle between transfers.
- Base register contained in the list with WB: no special handling. The writeback still occurs and its ordering relative to the load is the control unit's responsibility.
- MOC outside ACCESS is ignored.
- Reset mid-operation aborts immediately: no DONE, no WB_EN.
- Outputs are registered, except that MEM_ADDR/REG_IDX reflect the current state registers.

Test Plan:
- IA load, REG_LIST = 16'h000F, BASE = 0x100, WB = 1, MOC returned 1 cycle after each request → addresses 0x100, 0x104, 0x108, 0x10C with REG_IDX 0, 1, 2, 3; four RF_LD pulses; WB_ADDR = 0x110 with WB_EN and DONE in the same cycle.
- DB store, REG_LIST = 16'h8001, BASE = 0x200 → r0 at 0x1F8, r15 at 0x1FC; MEM_RW = 0; no RF_LD; WB_ADDR = 0x1F8.
- IB and DA with REG_LIST = 16'h0012, BASE = 0x40 → IB: r1 @ 0x44, r4 @ 0x48, WB 0x48. DA: r1 @ 0x3C, r4 @ 0x40, WB 0x38.
- Empty list, WB = 1 → DONE exactly 2 edges after START; MEM_REQ never high; WB_EN stays 0.
- MOC delayed 5 cycles on the second transfer, with START pulsed mid-operation → MEM_REQ, MEM_ADDR and REG_IDX held stable throughout; the extra START has no effect; GAP low cycle observed between transfers.
- RESET asserted asynchronously mid-ACCESS (e.g. 3 ns after an edge) → all outputs 0 immediately; no DONE; a new START after release runs normally from IDLE. Repeat with NREGS = 32, IDXW = 5, REG_LIST = 32'h8000_0001 (IA) → r0, then r31 at base+4.
